// File: rtl/idu_pkg.sv
// Shared IDU types: widths, wakeup bus count and the pipe4 issue payload that
// the issue queue stores and the RF stage registers.
package idu_pkg;

  localparam int IID_W    = 5;
  localparam int OPC_W    = 7;
  localparam int PREG_W   = 6;
  localparam int XLEN     = 64;
  localparam int NUM_WAKE = 8;

  // Fields handed from the pipe4 issue queue to the pipe4 RF stage.
  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [OPC_W-1:0]  opcode;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } pipe4_payload_t;

  // One issue-queue slot: payload plus queue bookkeeping.
  typedef struct packed {
    logic           vld;
    logic           rdy1;
    pipe4_payload_t pl;
  } pipe4_entry_t;

endpackage

// File: rtl/idu_is_wakeup.sv
// Compares one physical source register against every wakeup broadcast bus.
module idu_is_wakeup
  import idu_pkg::*;
(
  input  logic [PREG_W-1:0]          psrc,
  input  logic [NUM_WAKE-1:0]        wake_vld,
  input  logic [NUM_WAKE*PREG_W-1:0] wake_preg,
  output logic                       hit
);

  // Any valid bus carrying this preg produces a hit; preg 0 is not special.
  always_comb begin
    // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
    hit = 1'b0;
    for (int b = 0; b < NUM_WAKE; b++) begin
      if (wake_vld[b] && (wake_preg[b*PREG_W +: PREG_W] == psrc)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/idu_is_pipe4.sv
// Pipe4 issue queue: collapsing queue (slot 0 oldest), psrc1 wakeup from the
// ex-stage and cdb buses, oldest-ready select driving the pipe4 RF interface.
module idu_is_pipe4
  import idu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,

  input  logic              dis_pipe4_vld,
  output logic              dis_pipe4_rdy,
  input  logic [4:0]        dis_pipe4_iid,
  input  logic [6:0]        dis_pipe4_opcode,
  input  logic              dis_pipe4_psrc1_vld,
  input  logic [5:0]        dis_pipe4_psrc1,
  input  logic              dis_pipe4_psrc1_rdy,
  input  logic              dis_pipe4_imm_vld,
  input  logic [63:0]       dis_pipe4_imm,

  input  logic              exu_idu_rf_alu_ex_vld,
  input  logic [5:0]        exu_idu_rf_alu_ex_preg,
  input  logic              exu_idu_rf_alu_cdb_vld,
  input  logic [5:0]        exu_idu_rf_alu_cdb_preg,
  input  logic              exu_idu_rf_mxu_ex_vld,
  input  logic [5:0]        exu_idu_rf_mxu_ex_preg,
  input  logic              exu_idu_rf_mxu_cdb_vld,
  input  logic [5:0]        exu_idu_rf_mxu_cdb_preg,
  input  logic              exu_idu_rf_div_ex_vld,
  input  logic [5:0]        exu_idu_rf_div_ex_preg,
  input  logic              exu_idu_rf_div_cdb_vld,
  input  logic [5:0]        exu_idu_rf_div_cdb_preg,
  input  logic              exu_idu_rf_lsu_ex_vld,
  input  logic [5:0]        exu_idu_rf_lsu_ex_preg,
  input  logic              exu_idu_rf_lsu_cdb_vld,
  input  logic [5:0]        exu_idu_rf_lsu_cdb_preg,

  output logic              idu_idu_rf_pipe4_vld,
  output logic [4:0]        idu_idu_rf_pipe4_iid,
  output logic [6:0]        idu_idu_rf_pipe4_opcode,
  output logic              idu_idu_rf_pipe4_psrc1_vld,
  output logic [5:0]        idu_idu_rf_pipe4_psrc1,
  output logic              idu_idu_rf_pipe4_imm_vld,
  output logic [63:0]       idu_idu_rf_pipe4_imm,

  output logic [CNT_W-1:0]  pipe4_is_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pipe4_entry_t q     [DEPTH];
  pipe4_entry_t q_nxt [DEPTH];
  // Current slots with this cycle's wakeup folded in, plus an empty slot on
  // top so the collapse shift never reads past the end of the queue.
  pipe4_entry_t cur   [DEPTH+1];
  pipe4_entry_t new_entry;

  logic [NUM_WAKE-1:0]        wake_vld;
  logic [NUM_WAKE*PREG_W-1:0] wake_preg;
  logic [DEPTH:0]             hit;      // [DEPTH] is the dispatch port
  logic [DEPTH-1:0]           ready;

  logic                       sel_vld;
  logic [IDX_W-1:0]           sel_idx;
  pipe4_payload_t             iss;

  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [CNT_W-1:0]           enq_slot;
  logic                       enq;

  assign wake_vld = {exu_idu_rf_lsu_cdb_vld, exu_idu_rf_lsu_ex_vld,
                     exu_idu_rf_div_cdb_vld, exu_idu_rf_div_ex_vld,
                     exu_idu_rf_mxu_cdb_vld, exu_idu_rf_mxu_ex_vld,
                     exu_idu_rf_alu_cdb_vld, exu_idu_rf_alu_ex_vld};

  assign wake_preg = {exu_idu_rf_lsu_cdb_preg, exu_idu_rf_lsu_ex_preg,
                      exu_idu_rf_div_cdb_preg, exu_idu_rf_div_ex_preg,
                      exu_idu_rf_mxu_cdb_preg, exu_idu_rf_mxu_ex_preg,
                      exu_idu_rf_alu_cdb_preg, exu_idu_rf_alu_ex_preg};

  // One comparator per slot plus one for the uop being dispatched.
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    idu_is_wakeup u_wake (
      .psrc      (q[g].pl.psrc1),
      .wake_vld  (wake_vld),
      .wake_preg (wake_preg),
      .hit       (hit[g])
    );
  end

  idu_is_wakeup u_wake_dis (
    .psrc      (dis_pipe4_psrc1),
    .wake_vld  (wake_vld),
    .wake_preg (wake_preg),
    .hit       (hit[DEPTH])
  );

  // Per-slot readiness, including a same-cycle wakeup hit.
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = q[i].vld & (~q[i].pl.psrc1_vld | q[i].rdy1 | hit[i]);
    end
  end

  // Oldest-ready select: scanning downward leaves the lowest ready index.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    iss     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    if (sel_vld) begin
      iss = q[sel_idx].pl;
    end
  end

  assign idu_idu_rf_pipe4_vld       = sel_vld;
  assign idu_idu_rf_pipe4_iid       = iss.iid;
  assign idu_idu_rf_pipe4_opcode    = iss.opcode;
  assign idu_idu_rf_pipe4_psrc1_vld = iss.psrc1_vld;
  assign idu_idu_rf_pipe4_psrc1     = iss.psrc1;
  assign idu_idu_rf_pipe4_imm_vld   = iss.imm_vld;
  assign idu_idu_rf_pipe4_imm       = iss.imm;

  // Accept whenever a slot is free now; an issue this cycle is not credited.
  assign dis_pipe4_rdy = (cnt < CNT_W'(DEPTH));
  assign enq           = dis_pipe4_vld & dis_pipe4_rdy;
  assign enq_slot      = cnt - CNT_W'(sel_vld);
  assign pipe4_is_cnt  = cnt;

  // Build the dispatched entry; a same-cycle wakeup marks it ready at capture.
  always_comb begin
    new_entry              = '0;
    new_entry.vld          = 1'b1;
    new_entry.rdy1         = dis_pipe4_psrc1_rdy | hit[DEPTH];
    new_entry.pl.iid       = dis_pipe4_iid;
    new_entry.pl.opcode    = dis_pipe4_opcode;
    new_entry.pl.psrc1_vld = dis_pipe4_psrc1_vld;
    new_entry.pl.psrc1     = dis_pipe4_psrc1;
    new_entry.pl.imm_vld   = dis_pipe4_imm_vld;
    new_entry.pl.imm       = dis_pipe4_imm;
  end

  // Next queue image: sticky wakeup, collapse above the issued slot, enqueue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cur[i]      = q[i];
      cur[i].rdy1 = q[i].rdy1 | hit[i];
    end
    cur[DEPTH] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (sel_vld && (i >= int'(sel_idx))) begin
        q_nxt[i] = cur[i+1];
      end else begin
        q_nxt[i] = cur[i];
      end
      if (enq && (enq_slot == CNT_W'(i))) begin
        q_nxt[i] = new_entry;
      end
    end

    cnt_nxt = cnt + CNT_W'(enq) - CNT_W'(sel_vld);
  end

  // Queue state: reset beats flush, flush beats every other update.
  always_ff @(posedge clk) begin
    if (rst_clk || rtu_global_flush) begin
      // NOTE: only valid bits are cleared; payload in an invalid slot is never observed, so it needs no reset.
      for (int i = 0; i < DEPTH; i++) begin
        q[i].vld <= 1'b0;
      end
      cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every slot sees the pre-edge values.
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_idu_is_pipe4.sv
// Directed self-checking bench for the pipe4 issue queue.
module tb_idu_is_pipe4;

  logic        clk = 1'b0;
  logic        rst_clk;
  logic        rtu_global_flush;
  logic        dis_pipe4_vld;
  logic        dis_pipe4_rdy;
  logic [4:0]  dis_pipe4_iid;
  logic [6:0]  dis_pipe4_opcode;
  logic        dis_pipe4_psrc1_vld;
  logic [5:0]  dis_pipe4_psrc1;
  logic        dis_pipe4_psrc1_rdy;
  logic        dis_pipe4_imm_vld;
  logic [63:0] dis_pipe4_imm;
  logic        alu_ex_vld, alu_cdb_vld, mxu_ex_vld, mxu_cdb_vld;
  logic        div_ex_vld, div_cdb_vld, lsu_ex_vld, lsu_cdb_vld;
  logic [5:0]  alu_ex_preg, alu_cdb_preg, mxu_ex_preg, mxu_cdb_preg;
  logic [5:0]  div_ex_preg, div_cdb_preg, lsu_ex_preg, lsu_cdb_preg;
  logic        iss_vld;
  logic [4:0]  iss_iid;
  logic [6:0]  iss_opcode;
  logic        iss_psrc1_vld;
  logic [5:0]  iss_psrc1;
  logic        iss_imm_vld;
  logic [63:0] iss_imm;
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_is_pipe4 #(.DEPTH(4), .CNT_W(3)) dut (
    .clk                        (clk),
    .rst_clk                    (rst_clk),
    .rtu_global_flush           (rtu_global_flush),
    .dis_pipe4_vld              (dis_pipe4_vld),
    .dis_pipe4_rdy              (dis_pipe4_rdy),
    .dis_pipe4_iid              (dis_pipe4_iid),
    .dis_pipe4_opcode           (dis_pipe4_opcode),
    .dis_pipe4_psrc1_vld        (dis_pipe4_psrc1_vld),
    .dis_pipe4_psrc1            (dis_pipe4_psrc1),
    .dis_pipe4_psrc1_rdy        (dis_pipe4_psrc1_rdy),
    .dis_pipe4_imm_vld          (dis_pipe4_imm_vld),
    .dis_pipe4_imm              (dis_pipe4_imm),
    .exu_idu_rf_alu_ex_vld      (alu_ex_vld),
    .exu_idu_rf_alu_ex_preg     (alu_ex_preg),
    .exu_idu_rf_alu_cdb_vld     (alu_cdb_vld),
    .exu_idu_rf_alu_cdb_preg    (alu_cdb_preg),
    .exu_idu_rf_mxu_ex_vld      (mxu_ex_vld),
    .exu_idu_rf_mxu_ex_preg     (mxu_ex_preg),
    .exu_idu_rf_mxu_cdb_vld     (mxu_cdb_vld),
    .exu_idu_rf_mxu_cdb_preg    (mxu_cdb_preg),
    .exu_idu_rf_div_ex_vld      (div_ex_vld),
    .exu_idu_rf_div_ex_preg     (div_ex_preg),
    .exu_idu_rf_div_cdb_vld     (div_cdb_vld),
    .exu_idu_rf_div_cdb_preg    (div_cdb_preg),
    .exu_idu_rf_lsu_ex_vld      (lsu_ex_vld),
    .exu_idu_rf_lsu_ex_preg     (lsu_ex_preg),
    .exu_idu_rf_lsu_cdb_vld     (lsu_cdb_vld),
    .exu_idu_rf_lsu_cdb_preg    (lsu_cdb_preg),
    .idu_idu_rf_pipe4_vld       (iss_vld),
    .idu_idu_rf_pipe4_iid       (iss_iid),
    .idu_idu_rf_pipe4_opcode    (iss_opcode),
    .idu_idu_rf_pipe4_psrc1_vld (iss_psrc1_vld),
    .idu_idu_rf_pipe4_psrc1     (iss_psrc1),
    .idu_idu_rf_pipe4_imm_vld   (iss_imm_vld),
    .idu_idu_rf_pipe4_imm       (iss_imm),
    .pipe4_is_cnt               (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rtu_global_flush    = 1'b0;
    dis_pipe4_vld       = 1'b0;
    dis_pipe4_iid       = '0;
    dis_pipe4_opcode    = '0;
    dis_pipe4_psrc1_vld = 1'b0;
    dis_pipe4_psrc1     = '0;
    dis_pipe4_psrc1_rdy = 1'b0;
    dis_pipe4_imm_vld   = 1'b0;
    dis_pipe4_imm       = '0;
    {alu_ex_vld, alu_cdb_vld, mxu_ex_vld, mxu_cdb_vld} = '0;
    {div_ex_vld, div_cdb_vld, lsu_ex_vld, lsu_cdb_vld} = '0;
    {alu_ex_preg, alu_cdb_preg, mxu_ex_preg, mxu_cdb_preg} = '0;
    {div_ex_preg, div_cdb_preg, lsu_ex_preg, lsu_cdb_preg} = '0;
  endtask

  // Advance one clock; inputs go back to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  // Let combinational outputs settle before sampling, well ahead of the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic dispatch(input logic [4:0] iid, input logic psrc_vld,
                          input logic [5:0] psrc, input logic psrc_rdy,
                          input logic [63:0] imm);
    dis_pipe4_vld       = 1'b1;
    dis_pipe4_iid       = iid;
    dis_pipe4_opcode    = {2'b10, iid};
    dis_pipe4_psrc1_vld = psrc_vld;
    dis_pipe4_psrc1     = psrc;
    dis_pipe4_psrc1_rdy = psrc_rdy;
    dis_pipe4_imm_vld   = 1'b1;
    dis_pipe4_imm       = imm;
  endtask

  initial begin
    clr();
    rst_clk = 1'b1;
    tick();
    tick();
    rst_clk = 1'b0;
    settle();
    check("rst_vld", 64'(iss_vld), 64'd0);
    check("rst_iid", 64'(iss_iid), 64'd0);
    check("rst_imm", iss_imm, 64'd0);
    check("rst_rdy", 64'(dis_pipe4_rdy), 64'd1);
    check("rst_cnt", 64'(cnt), 64'd0);

    // 1: no-source uop issues the cycle after enqueue.
    dispatch(5'd3, 1'b0, 6'd0, 1'b0, 64'h10);
    settle();
    check("t1_no_bypass", 64'(iss_vld), 64'd0);
    tick();
    settle();
    check("t1_vld", 64'(iss_vld), 64'd1);
    check("t1_iid", 64'(iss_iid), 64'd3);
    check("t1_opc", 64'(iss_opcode), 64'h43);
    check("t1_imm", iss_imm, 64'h10);
    check("t1_immv", 64'(iss_imm_vld), 64'd1);
    check("t1_p1v", 64'(iss_psrc1_vld), 64'd0);
    check("t1_cnt1", 64'(cnt), 64'd1);
    tick();
    settle();
    check("t1_cnt0", 64'(cnt), 64'd0);
    check("t1_idle", 64'(iss_vld), 64'd0);

    // 2: waiting uop issues in the same cycle as its ALU ex wakeup.
    dispatch(5'd1, 1'b1, 6'd12, 1'b0, 64'h0);
    tick();
    settle();
    check("t2_wait", 64'(iss_vld), 64'd0);
    check("t2_cnt", 64'(cnt), 64'd1);
    tick();
    alu_ex_vld = 1'b1; alu_ex_preg = 6'd12;
    settle();
    check("t2_vld", 64'(iss_vld), 64'd1);
    check("t2_iid", 64'(iss_iid), 64'd1);
    check("t2_psrc", 64'(iss_psrc1), 64'd12);
    check("t2_p1v", 64'(iss_psrc1_vld), 64'd1);
    tick();
    settle();
    check("t2_cnt0", 64'(cnt), 64'd0);

    // 3: full queue, wake slot 2; rdy only returns after the collapse.
    dispatch(5'd5, 1'b1, 6'd30, 1'b0, 64'h5); tick();
    dispatch(5'd6, 1'b1, 6'd31, 1'b0, 64'h6); tick();
    dispatch(5'd7, 1'b1, 6'd32, 1'b0, 64'h7); tick();
    dispatch(5'd8, 1'b1, 6'd33, 1'b0, 64'h8); tick();
    settle();
    check("t3_full_rdy", 64'(dis_pipe4_rdy), 64'd0);
    check("t3_full_cnt", 64'(cnt), 64'd4);
    check("t3_none", 64'(iss_vld), 64'd0);
    mxu_cdb_vld = 1'b1; mxu_cdb_preg = 6'd32;
    settle();
    check("t3_vld", 64'(iss_vld), 64'd1);
    check("t3_iid", 64'(iss_iid), 64'd7);
    check("t3_imm", iss_imm, 64'h7);
    check("t3_rdy_nocredit", 64'(dis_pipe4_rdy), 64'd0);
    tick();
    settle();
    check("t3_cnt3", 64'(cnt), 64'd3);
    check("t3_rdy1", 64'(dis_pipe4_rdy), 64'd1);
    check("t3_none2", 64'(iss_vld), 64'd0);
    div_ex_vld = 1'b1; div_ex_preg = 6'd33;
    settle();
    check("t3_shift_iid", 64'(iss_iid), 64'd8);
    tick();
    settle();
    check("t3_cnt2", 64'(cnt), 64'd2);

    // 4: both remaining entries woken together; oldest first, then the other.
    alu_cdb_vld = 1'b1; alu_cdb_preg = 6'd30;
    lsu_ex_vld  = 1'b1; lsu_ex_preg  = 6'd31;
    settle();
    check("t4_first", 64'(iss_iid), 64'd5);
    tick();
    settle();
    check("t4_second_vld", 64'(iss_vld), 64'd1);
    check("t4_second", 64'(iss_iid), 64'd6);
    tick();
    settle();
    check("t4_empty", 64'(cnt), 64'd0);

    // 5: wakeup seen at dispatch is captured into the entry.
    dispatch(5'd9, 1'b1, 6'd20, 1'b0, 64'h9);
    lsu_cdb_vld = 1'b1; lsu_cdb_preg = 6'd20;
    settle();
    check("t5_no_bypass", 64'(iss_vld), 64'd0);
    tick();
    settle();
    check("t5_vld", 64'(iss_vld), 64'd1);
    check("t5_iid", 64'(iss_iid), 64'd9);
    tick();

    // Preg 0 wakes like any other preg; div cdb bus wakes a second waiter.
    dispatch(5'd10, 1'b1, 6'd0, 1'b0, 64'hA); tick();
    dispatch(5'd19, 1'b1, 6'd45, 1'b0, 64'h13); tick();
    settle();
    check("p0_wait", 64'(iss_vld), 64'd0);
    mxu_ex_vld = 1'b1; mxu_ex_preg = 6'd0;
    settle();
    check("p0_iid", 64'(iss_iid), 64'd10);
    tick();
    settle();
    check("dcdb_wait", 64'(iss_vld), 64'd0);
    div_cdb_vld = 1'b1; div_cdb_preg = 6'd45;
    settle();
    check("dcdb_iid", 64'(iss_iid), 64'd19);
    tick();

    // Enqueue and issue in the same cycle: count holds, new uop follows.
    dispatch(5'd11, 1'b1, 6'd50, 1'b1, 64'hB); tick();
    dispatch(5'd12, 1'b0, 6'd0, 1'b0, 64'hC);
    settle();
    check("ei_iid", 64'(iss_iid), 64'd11);
    tick();
    settle();
    check("ei_cnt", 64'(cnt), 64'd1);
    check("ei_next", 64'(iss_iid), 64'd12);
    check("ei_imm", iss_imm, 64'hC);
    tick();
    settle();
    check("ei_cnt0", 64'(cnt), 64'd0);

    // 6: flush with a concurrent dispatch empties the queue and drops the uop.
    dispatch(5'd13, 1'b1, 6'd40, 1'b0, 64'h0); tick();
    dispatch(5'd14, 1'b1, 6'd41, 1'b0, 64'h0); tick();
    dispatch(5'd15, 1'b1, 6'd42, 1'b0, 64'h0); tick();
    settle();
    check("fl_cnt3", 64'(cnt), 64'd3);
    rtu_global_flush = 1'b1;
    dispatch(5'd16, 1'b0, 6'd0, 1'b0, 64'h16);
    tick();
    settle();
    check("fl_cnt0", 64'(cnt), 64'd0);
    check("fl_no_issue", 64'(iss_vld), 64'd0);
    check("fl_rdy", 64'(dis_pipe4_rdy), 64'd1);
    tick();
    settle();
    check("fl_dropped", 64'(iss_vld), 64'd0);

    // Reset mid-operation overrides a pending dispatch and queued work.
    dispatch(5'd17, 1'b0, 6'd0, 1'b0, 64'h17); tick();
    dispatch(5'd18, 1'b0, 6'd0, 1'b0, 64'h18);
    rst_clk = 1'b1;
    tick();
    rst_clk = 1'b0;
    settle();
    check("mr_vld", 64'(iss_vld), 64'd0);
    check("mr_iid", 64'(iss_iid), 64'd0);
    check("mr_cnt", 64'(cnt), 64'd0);
    tick();
    settle();
    check("mr_after", 64'(iss_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
